// File: rtl/parity_check_pkg.sv
// Shared definitions for the serial parity checker: FSM encodings, parity
// mode constants and the expected-parity helper.
package parity_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Expected parity bit from the running XOR of the data bits and the mode.
  function automatic logic expected_parity(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/parity_err_counter.sv
// Saturating event counter for parity errors; cleared only by reset.
module parity_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parity_check_seq.sv
// Serial even/odd parity checker for the UART receive path: DATA_W data bits
// LSB first, then one parity bit. Optional error counter: PARITY_CHECK_ERR_CNT_EN.
module parity_check_seq
  import parity_check_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              odd_mode,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_error,
  output logic [1:0]        dbg_state
`ifdef PARITY_CHECK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int CNT_BITS = $clog2(DATA_W);

  generate
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
      $error("parity_check_seq: DATA_W must be in 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("parity_check_seq: CNT_W must be at least 1");
    end
  endgenerate

  state_t              state;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic                acc;
  logic                odd_q;

  // Handshake: a frame bit is consumed only in a cycle with enable & bit_valid
  // & ~start; start (with enable) always wins and restarts the frame, and with
  // enable low every input is ignored and all state holds.
  logic start_ok;
  logic bit_ok;
  logic last_data_bit;
  logic frame_end;
  logic bit_mismatch;

  assign start_ok      = enable & start;
  assign bit_ok        = enable & ~start & bit_valid;
  assign last_data_bit = (bit_cnt == CNT_BITS'(DATA_W - 1));
  assign frame_end     = bit_ok & (state == ST_PARITY);
  assign bit_mismatch  = bit_in ^ expected_parity(acc, odd_q);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      acc          <= 1'b0;
      odd_q        <= PAR_EVEN;
      busy         <= 1'b0;
      done         <= 1'b0;
      data_out     <= '0;
      parity_error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        // Also the abort path: a frame in progress is dropped without done.
        state     <= ST_DATA;
        bit_cnt   <= '0;
        shift_reg <= '0;
        acc       <= 1'b0;
        odd_q     <= odd_mode;
        busy      <= 1'b1;
      end else if (bit_ok) begin
        case (state)
          ST_DATA: begin
            shift_reg[bit_cnt] <= bit_in;
            acc                <= acc ^ bit_in;
            bit_cnt            <= bit_cnt + 1'b1;
            if (last_data_bit) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_error <= bit_mismatch;
            data_out     <= shift_reg;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PARITY_CHECK_ERR_CNT_EN
  // Counts on the same edge that raises done, so err_count tracks the frame.
  parity_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_end & bit_mismatch),
    .count (err_count)
  );
`endif

endmodule

// File: doc/parity_check_seq.md
Name: parity_check_seq

Overview:
- Serial, parametrised successor to the combinational even-parity checker in the UART receive path.
- Accepts a frame one bit at a time from the RX bit sampler: DATA_W data bits, LSB first, then one parity bit.
- Accumulates parity on the fly, supports runtime even/odd mode, and reports a per-frame done pulse with parity_error and the assembled word.

Parameters:
- DATA_W, 8, number of data bits per frame (legal 2..32).
- CNT_W, 8, width of the saturating parity-error counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  block enable; when low, bit_valid and start are ignored and state is held.
- start  input  1  single-cycle pulse: begin a new frame.
- odd_mode  input  1  parity mode, 0 = even, 1 = odd; sampled only when start is accepted.
- bit_valid  input  1  strobe: bit_in is a valid frame bit this cycle.
- bit_in  input  1  serial frame bit.
- busy  output  1  high while a frame is in progress (DATA or PARITY state).
- done  output  1  one-cycle pulse: frame complete, data_out and parity_error valid.
- data_out  output  DATA_W  assembled data word, held until the next done.
- parity_error  output  1  1 = received parity bit differs from the expected bit; held until the next done.
- err_count  output  CNT_W  saturating count of parity errors (optional feature only).

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE, accumulator = 0, bit counter = 0.
  - busy = 0, done = 0, data_out = 0, parity_error = 0, err_count = 0.
- States: IDLE, DATA, PARITY; binary encoded, all registers synchronous.
- IDLE:
  - enable & start → DATA.
  - Clear accumulator, clear bit counter and shift register.
  - Latch odd_mode into odd_q.
- DATA, on each enable & bit_valid:
  - shift_reg[cnt] = bit_in (LSB first).
  - acc = acc ^ bit_in.
  - cnt = cnt + 1.
  - On the bit where cnt == DATA_W-1 → PARITY.
- PARITY, on enable & bit_valid:
  - expected = acc ^ odd_q.
  - Register parity_error = (bit_in != expected).
  - data_out = shift_reg.
  - Assert done for exactly one cycle; → IDLE.
- Latency: done, data_out and parity_error update on the clock edge that samples the parity bit, so they are visible the following cycle.
- busy is registered; it is 1 in the cycle after start is accepted through the cycle the parity bit is sampled.
- start while busy: the current frame is aborted without a done pulse; the block restarts at DATA with counters cleared and odd_mode re-latched.
- start and bit_valid in the same cycle in IDLE: start is taken; that bit_valid is ignored.
- bit_valid in IDLE is ignored.
- enable low mid-frame: freeze all state; done is not asserted.
- Reset mid-frame: immediate return to the reset values above; no done pulse.
- Back-to-back frames: start may arrive in the cycle done is high; done still pulses for the completed frame.

Optional Feature:
- Macro: PARITY_CHECK_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 in the cycle a done occurs with parity_error = 1.
  - err_count saturates at 2^CNT_W - 1 and clears only on reset.
- Undefined: the err_count port is absent and no counter logic is generated.

Decomposition:
- Shared package parity_check_pkg holds:
  - state encodings ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PARITY = 2'd2;
  - mode constants PAR_EVEN = 1'b0, PAR_ODD = 1'b1.
- One natural sub-module, parity_err_counter (saturating counter), instantiated only under PARITY_CHECK_ERR_CNT_EN; everything else stays inline.

Test Plan:
- Even mode, DATA_W=8, bits of 0xA5 then parity 0 → one done pulse, data_out=0xA5, parity_error=0.
- Even mode, 0xA5 then parity 1 → parity_error=1; err_count 0→1 with the feature enabled.
- Odd mode, 0x01 then parity 0 → parity_error=0; same frame with parity 1 → parity_error=1.
- Start pulsed after 4 data bits, then a full 0x3C frame with parity 0 (even) → only one done pulse, data_out=0x3C, no error.
- enable dropped for 5 cycles mid-frame with bit_valid toggling → bits ignored; frame completes correctly once enable returns.
- CNT_W=2, five consecutive error frames → err_count reads 1, 2, 3, 3, 3; reset low for one cycle → all outputs 0.
